// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command-side sequencer:
// ALU function encodings, the command opcode for multiply, and the
// sequencer state type.
package alu_pkg;

    localparam int unsigned ALU_F_W = 3;
    localparam int unsigned OP_W    = 4;

    // ALU F encodings (011 is passed through; meaning undefined)
    localparam logic [ALU_F_W-1:0] ALU_AND  = 3'b000;
    localparam logic [ALU_F_W-1:0] ALU_OR   = 3'b001;
    localparam logic [ALU_F_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [ALU_F_W-1:0] ALU_ANDN = 3'b100;
    localparam logic [ALU_F_W-1:0] ALU_ORN  = 3'b101;
    localparam logic [ALU_F_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALU_F_W-1:0] ALU_SLT  = 3'b111;

    // Any opcode with bit 3 set runs the iterative multiply
    localparam logic [OP_W-1:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DONE
    } alu_seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Command-side driver for the external combinational ALU.
// Accepts one operation on the cmd valid/ready port, drives the ALU
// (one pass for plain ops, N ADD passes for MUL), and returns the
// result on the rsp valid/ready port. No command buffering.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op, cmd_a, cmd_b payload
//   rsp_valid/rsp_ready   response handshake; rsp_y, rsp_cout, rsp_zf payload
//   alu_a, alu_b, alu_f   to the ALU inputs (zero while idle or done)
//   alu_y, alu_cout       from the ALU outputs
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic [N-1:0]         cmd_a,
    input  logic [N-1:0]         cmd_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_y,
    output logic                 rsp_cout,
    output logic                 rsp_zf,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [ALU_F_W-1:0]   alu_f,
    input  logic [N-1:0]         alu_y,
    input  logic                 alu_cout
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    alu_seq_state_t     state;
    logic [N-1:0]       mplier;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       acc_next;

    // During MUL the alu_a/alu_b registers double as accumulator and
    // shifted multiplicand, so the ALU always sees acc + mcand.
    always_comb begin
        acc_next = mplier[0] ? alu_y : alu_a;
    end

    // Sequencer FSM with registered handshake, ALU and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_cout  <= 1'b0;
            rsp_zf    <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= ALU_AND;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        if (!cmd_op[3]) begin
                            alu_a  <= cmd_a;
                            alu_b  <= cmd_b;
                            alu_f  <= cmd_op[ALU_F_W-1:0];
                            mplier <= '0;
                            state  <= ST_EXEC;
                        end else begin
                            alu_a  <= '0;
                            alu_b  <= cmd_a;
                            alu_f  <= ALU_ADD;
                            mplier <= cmd_b;
                            state  <= ST_MUL;
                        end
                    end
                end

                ST_EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_cout  <= alu_cout;
                    rsp_zf    <= (alu_y == '0);
                    rsp_valid <= 1'b1;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_f     <= ALU_AND;
                    state     <= ST_DONE;
                end

                ST_MUL: begin
                    if (cnt == CNT_LAST) begin
                        // Last pass: take the final accumulator, carry is not meaningful
                        rsp_y     <= acc_next;
                        rsp_cout  <= 1'b0;
                        rsp_zf    <= (acc_next == '0);
                        rsp_valid <= 1'b1;
                        alu_a     <= '0;
                        alu_b     <= '0;
                        alu_f     <= ALU_AND;
                        mplier    <= '0;
                        cnt       <= '0;
                        state     <= ST_DONE;
                    end else begin
                        alu_a  <= acc_next;
                        alu_b  <= alu_b << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU beside the DUT, a cycle-level
// reference of the expected handshake/ALU/response behaviour, directed
// cases with literal expectations, and randomized traffic with backpressure.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned N = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_op;
    logic [N-1:0]   cmd_a;
    logic [N-1:0]   cmd_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [N-1:0]   rsp_y;
    logic           rsp_cout;
    logic           rsp_zf;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [2:0]     alu_f;
    logic [N-1:0]   alu_y;
    logic           alu_cout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    alu_sequencer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout),
        .rsp_zf    (rsp_zf),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: adder on A and (optionally inverted) B, SLT = sign of A-B
    logic [N:0]   alu_s;
    logic [N-1:0] alu_bb;
    always_comb begin
        alu_bb = alu_f[2] ? ~alu_b : alu_b;
        alu_s  = {1'b0, alu_a} + {1'b0, alu_bb} + (N+1)'(alu_f[2]);
        case (alu_f[1:0])
            2'b00:   alu_y = alu_a & alu_bb;
            2'b01:   alu_y = alu_a | alu_bb;
            2'b10:   alu_y = alu_s[N-1:0];
            default: alu_y = alu_f[2] ? N'(alu_s[N-1]) : '0;
        endcase
        alu_cout = alu_s[N];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s cycle=%0d got=timeout want=event", name, cyc);
    endtask

    // Expected result from plain arithmetic
    function automatic logic [N-1:0] ref_y(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0]  p;
        logic [N-1:0] d;
        if (op[3]) begin
            p = 64'(a) * 64'(b);
            return p[N-1:0];
        end
        d = a - b;
        case (op[2:0])
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return d;
            3'd7:    return N'(d[N-1]);
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_cout(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0] s;
        if (op[3]) return 1'b0;
        if (op[2]) return (a >= b);
        s = 64'(a) + 64'(b);
        return (s >> N) != 64'd0;
    endfunction

    // Reference: 0 idle, 1 busy (k-th execute cycle), 2 response pending
    int           m_st = 0;
    int           m_k  = 0;
    logic [3:0]   m_op;
    logic [N-1:0] m_a;
    logic [N-1:0] m_b;

    always @(negedge clk) begin : cmp
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [2:0]   ef;
        logic [63:0]  mk;
        logic [63:0]  pp;
        int           i;
        cyc++;
        if (armed) begin
            ea = '0;
            eb = '0;
            ef = 3'b000;
            if (m_st == 1) begin
                if (m_op[3]) begin
                    i  = m_k - 1;
                    mk = (64'd1 << i) - 64'd1;
                    pp = 64'(m_a) * (64'(m_b) & mk);
                    ea = pp[N-1:0];
                    pp = 64'(m_a) << i;
                    eb = pp[N-1:0];
                    ef = ALU_ADD;
                end else begin
                    ea = m_a;
                    eb = m_b;
                    ef = m_op[2:0];
                end
            end
            chk("cmd_ready", 64'(cmd_ready), 64'(m_st == 0));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_st == 2));
            chk("alu_a", 64'(alu_a), 64'(ea));
            chk("alu_b", 64'(alu_b), 64'(eb));
            chk("alu_f", 64'(alu_f), 64'(ef));
            if (m_st == 2) begin
                chk("rsp_y", 64'(rsp_y), 64'(ref_y(m_op, m_a, m_b)));
                chk("rsp_cout", 64'(rsp_cout), 64'(ref_cout(m_op, m_a, m_b)));
                chk("rsp_zf", 64'(rsp_zf), 64'(ref_y(m_op, m_a, m_b) == '0));
            end
        end
        if (reset) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (cmd_valid) begin
                    m_st = 1; m_k = 1;
                    m_op = cmd_op; m_a = cmd_a; m_b = cmd_b;
                end
                1: if (m_k == (m_op[3] ? int'(N) : 1)) m_st = 2;
                   else m_k++;
                default: if (rsp_ready) m_st = 0;
            endcase
        end
    end

    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("issue");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic await(output logic [N-1:0] y, output logic c, output logic z, output int lat);
        lat = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) timeout_fail("await");
        y = rsp_y; c = rsp_cout; z = rsp_zf;
    endtask

    // Finish the response handshake, optionally with random stalls and junk commands
    task automatic release_rsp(input bit rnd);
        bit ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (rsp_valid && rsp_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rnd) begin
                cmd_valid = $urandom_range(0, 1) != 0;
                cmd_op = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail("release");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    function automatic logic [N-1:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return N'($urandom_range(0, 15));
            1:       return '1;
            2:       return '0;
            3:       return N'(32'h8000_0000);
            default: return N'($urandom);
        endcase
    endfunction

    initial begin : stim
        logic [N-1:0] y;
        logic         c;
        logic         z;
        int           lat;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; armed = 1'b1;
        @(negedge clk);
        chk("rst_rsp_y", 64'(rsp_y), 64'd0);
        chk("rst_rsp_zf", 64'(rsp_zf), 64'd1);
        chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);

        issue(4'b0010, 5, 7); await(y, c, z, lat);
        chk("add_y", 64'(y), 64'd12); chk("add_cout", 64'(c), 64'd0);
        chk("add_zf", 64'(z), 64'd0); chk("add_lat", 64'(lat), 64'd2);
        release_rsp(1'b0);

        issue(4'b0110, 3, 3); await(y, c, z, lat);
        chk("sub_y", 64'(y), 64'd0); chk("sub_cout", 64'(c), 64'd1); chk("sub_zf", 64'(z), 64'd1);
        release_rsp(1'b0);

        issue(4'b0111, 32'hFFFF_FFFF, 1); await(y, c, z, lat);
        chk("slt_y", 64'(y), 64'd1);
        release_rsp(1'b0);
        issue(4'b0111, 1, 32'hFFFF_FFFF); await(y, c, z, lat);
        chk("slt_swap_y", 64'(y), 64'd0);
        release_rsp(1'b0);

        issue(OP_MUL, 6, 7); await(y, c, z, lat);
        chk("mul_y", 64'(y), 64'd42); chk("mul_cout", 64'(c), 64'd0); chk("mul_lat", 64'(lat), 64'd33);
        release_rsp(1'b0);
        issue(4'b1111, 32'h0001_0000, 32'h0001_0000); await(y, c, z, lat);
        chk("mul_ovf_y", 64'(y), 64'd0); chk("mul_ovf_zf", 64'(z), 64'd1);
        release_rsp(1'b0);

        // Backpressure with an ignored command while the response is pending
        rsp_ready = 1'b0;
        issue(4'b0010, 1, 1); await(y, c, z, lat);
        chk("bp_y", 64'(y), 64'd2);
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = 9; cmd_b = 9;
            @(negedge clk);
            chk("bp_hold_y", 64'(rsp_y), 64'd2);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        release_rsp(1'b0);
        issue(4'b0010, 3, 4); await(y, c, z, lat);
        chk("after_bp_y", 64'(y), 64'd7);
        release_rsp(1'b0);

        // Reset in the middle of a multiply
        issue(OP_MUL, 123, 456);
        repeat (9) @(negedge clk);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("midrst_y", 64'(rsp_y), 64'd0);
        chk("midrst_zf", 64'(rsp_zf), 64'd1);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_alu_a", 64'(alu_a), 64'd0);
        repeat (40) @(negedge clk);
        issue(4'b0010, 2, 2); await(y, c, z, lat);
        chk("post_rst_y", 64'(y), 64'd4);
        release_rsp(1'b0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            rsp_ready = $urandom_range(0, 1) != 0;
            issue(4'($urandom), rnd_operand(), rnd_operand());
            await(y, c, z, lat);
            release_rsp(1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side driver for the team's combinational N-bit ALU. Accepts operations over a valid/ready command port, drives the ALU's `A`/`B`/`F` inputs, captures `Y`/`Cout`/`zf`, and returns the result over a valid/ready response port. Single-pass ops take one execute cycle. `MUL` (low N bits of the product) is built iteratively from N ALU `ADD` passes. The ALU instance stays outside this block; the sequencer sits between the control path and the ALU.

## Interface
- `N`, default 32: datapath width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  4  operation. `0xxx` = pass `F=cmd_op[2:0]` straight through. `1000` = MUL. `1001`–`1111` are reserved and treated as MUL.
- `cmd_a`, `cmd_b`  in  N  operands.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_y`  out  N  result.
- `rsp_cout`  out  1  ALU carry for single-pass ops; 0 for MUL.
- `rsp_zf`  out  1  `rsp_y==0`.
- `alu_a`, `alu_b`  out  N  to ALU `A`, `B`.
- `alu_f`  out  3  to ALU `F`.
- `alu_y`  in  N  from ALU `Y`.
- `alu_cout`  in  1  from ALU `Cout`.

## Operation
- ALU F encodings:
  - 000 AND, 001 OR, 010 ADD
  - 100 A&~B, 101 A|~B, 110 SUB, 111 SLT (signed, via sign of A−B; result in bit 0)
  - 011 is passed through unchanged; its meaning is undefined.
- States:
  - **IDLE**: `cmd_ready=1`. On `cmd_valid&&cmd_ready`:
    - latch `op`, `a`, `b`.
    - If `op[3]=0`, go to EXEC.
    - Otherwise go to MUL with `acc=0`, `mcand=a`, `mplier=b`, `cnt=0`.
  - **EXEC** (1 cycle): drive `alu_a=a`, `alu_b=b`, `alu_f=op[2:0]`. Capture `rsp_y=alu_y`, `rsp_cout=alu_cout`. Go to DONE.
  - **MUL** (exactly N cycles, no early exit): drive `alu_a=acc`, `alu_b=mcand`, `alu_f=010`. Each cycle:
    - if `mplier[0]`, `acc<=alu_y`;
    - `mcand<=mcand<<1`;
    - `mplier<=mplier>>1`;
    - `cnt<=cnt+1`.
    - When `cnt==N-1`, capture the final acc into `rsp_y`, set `rsp_cout=0`, go to DONE.
    - Overflow beyond N bits is discarded.
  - **DONE**: `rsp_valid=1`, response registers held stable. On `rsp_ready`, go to IDLE.
- `cmd_ready` is asserted only in IDLE, so no new command is accepted while a response is pending. No command buffering.
- In IDLE and DONE: `alu_a=0`, `alu_b=0`, `alu_f=000`.
- `rsp_zf` is computed from the registered `rsp_y`.
- `cnt` width is `$clog2(N)`.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `rsp_valid=0`, `rsp_y=0`, `rsp_cout=0`, `rsp_zf=1`, `alu_a=0`, `alu_b=0`, `alu_f=000`. All internal registers are 0.
- Single-pass: command accepted at edge k. EXEC is the cycle after k. `rsp_valid` is high from edge k+2. Latency is 2 cycles.
- MUL: accepted at edge k, `rsp_valid` high from edge k+N+1. Latency is N+1 cycles.
- DONE→IDLE on the edge where `rsp_ready=1`. `cmd_ready` rises in the next cycle. Minimum command spacing is 3 cycles (single-pass) or N+2 cycles (MUL).
- `rsp_valid` and the response data must not change while `rsp_valid&&!rsp_ready`.
- `cmd_valid` asserted outside IDLE is ignored. No implicit capture occurs.
- Reset mid-operation (EXEC/MUL/DONE): the next edge returns to reset values. The in-flight result is lost and no response is issued.
- `reset` takes priority over all handshakes in the same cycle.

## Structure
- Shared package `alu_pkg` holds:
  - the F encoding constants (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_ANDN`, `ALU_ORN`, `ALU_SUB`, `ALU_SLT`);
  - the `cmd_op` constant `OP_MUL`;
  - the state enum type `alu_seq_state_t`.
- No sub-module is needed. The FSM, operand and iteration registers, and response registers live in this block. The bench instantiates the existing ALU beside it and wires `alu_*` to it.

## Test plan
- ADD `a=5`, `b=7`, `op=0010` → `rsp_y=12`, `cout=0`, `zf=0`, `rsp_valid` 2 cycles after accept.
- SUB `a=3`, `b=3`, `op=0110` → `rsp_y=0`, `cout=1`, `zf=1`.
- SLT `a=0xFFFFFFFF`, `b=1`, `op=0111` → `rsp_y=1`; swapped operands → `rsp_y=0`.
- MUL `a=6`, `b=7` → `rsp_y=42`, `cout=0`, `rsp_valid` exactly 33 cycles after accept. MUL `a=0x10000`, `b=0x10000` → `rsp_y=0`, `zf=1`.
- Backpressure: ADD 1+1 with `rsp_ready` low 5 cycles → `rsp_y=2` held stable, `cmd_ready=0` throughout, and a second `cmd_valid` is ignored. Release → IDLE, next command accepted.
- Reset at cycle 10 of a MUL → next cycle all outputs at reset values. No `rsp_valid` pulse follows. A subsequent ADD 2+2 returns 4.
